// File: rtl/seg_exc_sequencer.sv
// Segment-limit exception sequencer: drains older work, flushes the pipe,
// pushes the four-dword fault frame and redirects fetch to the #SS/#GP handler.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for a valid faulting AG instruction
// ST_DRAIN    | stalling AG until all older instructions have retired
// ST_FLUSH    | one-cycle kill of all non-retired instructions
// ST_PUSH     | four stack writes: EFLAGS, CS, EIP, error code
// ST_VECTOR   | one-cycle EIP/ESP load toward the handler
// ST_SHUTDOWN | fault during frame push; halted until reset
module seg_exc_sequencer #(
   parameter logic [31:0] IDT_BASE = 32'h0000_0000,
   parameter logic [2:0]  SS_ID    = 3'd2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        AG_V,
   input  logic        AG_EXC,
   input  logic [2:0]  AG_SEG_ID,
   input  logic [31:0] AG_EIP,
   input  logic [15:0] AG_CS,
   input  logic [31:0] EFLAGS,
   input  logic [31:0] ESP,
   input  logic        OLDER_EMPTY,
   output logic        STALL_AG,
   output logic        FLUSH,
   output logic        MEM_WR_REQ,
   output logic [31:0] MEM_WR_ADDR,
   output logic [31:0] MEM_WR_DATA,
   input  logic        MEM_WR_ACK,
   input  logic        PUSH_EXC,
   output logic        LD_EIP,
   output logic [31:0] NEW_EIP,
   output logic [31:0] ESP_OUT,
   output logic        LD_ESP,
   output logic        HALT,
   output logic        BUSY
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_FLUSH,
      ST_PUSH,
      ST_VECTOR,
      ST_SHUTDOWN
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] eip_q;
   logic [31:0] eflags_q;
   logic [31:0] esp_q;
   logic [15:0] cs_q;
   logic        vec_ss_q;
   logic [1:0]  k_q;
   logic        req_q;
   logic        busy_q;
   logic [31:0] push_off;
   logic [31:0] push_data;
   logic        capture;
   logic        ack_taken;

   assign capture   = (state == ST_IDLE) && AG_V && AG_EXC;
   assign ack_taken = (state == ST_PUSH) && req_q && MEM_WR_ACK;

   // next-state decode; an ACK only counts while a request is outstanding
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (capture) state_nxt = ST_DRAIN;
         ST_DRAIN:    if (OLDER_EMPTY) state_nxt = ST_FLUSH;
         ST_FLUSH:    state_nxt = ST_PUSH;
         ST_PUSH: begin
            if (ack_taken) begin
               if (PUSH_EXC)          state_nxt = ST_SHUTDOWN;
               else if (k_q == 2'd3)  state_nxt = ST_VECTOR;
            end
         end
         ST_VECTOR:   state_nxt = ST_IDLE;
         ST_SHUTDOWN: state_nxt = ST_SHUTDOWN;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // state register plus registered stall/busy so they track the next state
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt != ST_IDLE);
      end
   end

   // snapshot of the faulting instruction's architectural context
   always_ff @(posedge CLK) begin
      if (RST) begin
         eip_q    <= 32'h0;
         eflags_q <= 32'h0;
         esp_q    <= 32'h0;
         cs_q     <= 16'h0;
         vec_ss_q <= 1'b0;
      end else if (capture) begin
         eip_q    <= AG_EIP;
         eflags_q <= EFLAGS;
         esp_q    <= ESP;
         cs_q     <= AG_CS;
         vec_ss_q <= (AG_SEG_ID == SS_ID);
      end
   end

   // push index and request: one idle cycle precedes every request
   always_ff @(posedge CLK) begin
      if (RST) begin
         req_q <= 1'b0;
         k_q   <= 2'd0;
      end else if (state == ST_PUSH) begin
         if (!req_q) begin
            req_q <= 1'b1;
         end else if (MEM_WR_ACK) begin
            req_q <= 1'b0;
            k_q   <= k_q + 2'd1;
         end
      end else begin
         req_q <= 1'b0;
         k_q   <= 2'd0;
      end
   end

   assign push_off = {28'h0, k_q, 2'b00} + 32'd4;

   // frame layout from high to low address: EFLAGS, CS, EIP, error code
   always_comb begin
      push_data = 32'h0;
      case (k_q)
         2'd0:    push_data = eflags_q;
         2'd1:    push_data = {16'h0, cs_q};
         2'd2:    push_data = eip_q;
         default: push_data = 32'h0;
      endcase
   end

   assign MEM_WR_REQ  = req_q;
   assign MEM_WR_ADDR = req_q ? (esp_q - push_off) : 32'h0;
   assign MEM_WR_DATA = req_q ? push_data : 32'h0;
   assign FLUSH       = (state == ST_FLUSH);
   assign LD_EIP      = (state == ST_VECTOR);
   assign LD_ESP      = (state == ST_VECTOR);
   assign NEW_EIP     = (state == ST_VECTOR) ?
                        (IDT_BASE + (vec_ss_q ? 32'h60 : 32'h68)) : 32'h0;
   assign ESP_OUT     = (state == ST_VECTOR) ? (esp_q - 32'd16) : 32'h0;
   assign HALT        = (state == ST_SHUTDOWN);
   assign STALL_AG    = busy_q;
   assign BUSY        = busy_q;

endmodule

// File: tb/tb_seg_exc_sequencer.sv
// Directed bench for seg_exc_sequencer: a table of fault scenarios with
// hand-computed frame writes and redirect targets, plus a reset-mid-push case.
module tb_seg_exc_sequencer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        AG_V;
   logic        AG_EXC;
   logic [2:0]  AG_SEG_ID;
   logic [31:0] AG_EIP;
   logic [15:0] AG_CS;
   logic [31:0] EFLAGS;
   logic [31:0] ESP;
   logic        OLDER_EMPTY;
   logic        STALL_AG;
   logic        FLUSH;
   logic        MEM_WR_REQ;
   logic [31:0] MEM_WR_ADDR;
   logic [31:0] MEM_WR_DATA;
   logic        MEM_WR_ACK;
   logic        PUSH_EXC;
   logic        LD_EIP;
   logic [31:0] NEW_EIP;
   logic [31:0] ESP_OUT;
   logic        LD_ESP;
   logic        HALT;
   logic        BUSY;

   int errors = 0;
   int checks = 0;

   seg_exc_sequencer dut (
      .CLK(CLK), .RST(RST), .AG_V(AG_V), .AG_EXC(AG_EXC), .AG_SEG_ID(AG_SEG_ID),
      .AG_EIP(AG_EIP), .AG_CS(AG_CS), .EFLAGS(EFLAGS), .ESP(ESP),
      .OLDER_EMPTY(OLDER_EMPTY), .STALL_AG(STALL_AG), .FLUSH(FLUSH),
      .MEM_WR_REQ(MEM_WR_REQ), .MEM_WR_ADDR(MEM_WR_ADDR), .MEM_WR_DATA(MEM_WR_DATA),
      .MEM_WR_ACK(MEM_WR_ACK), .PUSH_EXC(PUSH_EXC), .LD_EIP(LD_EIP),
      .NEW_EIP(NEW_EIP), .ESP_OUT(ESP_OUT), .LD_ESP(LD_ESP), .HALT(HALT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0]       seg;
      logic [31:0]      eip;
      logic [15:0]      cs;
      logic [31:0]      efl;
      logic [31:0]      esp;
      int               drain;
      int               ack_dly;
      int               exc_push;
      int               n_wr;
      logic [3:0][31:0] addr;
      logic [3:0][31:0] data;
      logic [31:0]      new_eip;
      logic [31:0]      esp_out;
      logic             halt;
   } vec_t;

   vec_t vecs[5];

   function automatic vec_t mk(input logic [2:0] seg, input logic [31:0] eip,
                               input logic [15:0] cs, input logic [31:0] efl,
                               input logic [31:0] esp, input int drain, input int ack_dly,
                               input int exc_push, input int n_wr,
                               input logic [127:0] addr, input logic [127:0] data,
                               input logic [31:0] new_eip, input logic [31:0] esp_out,
                               input logic halt);
      vec_t v;
      v.seg = seg; v.eip = eip; v.cs = cs; v.efl = efl; v.esp = esp;
      v.drain = drain; v.ack_dly = ack_dly; v.exc_push = exc_push; v.n_wr = n_wr;
      v.addr = addr; v.data = data;
      v.new_eip = new_eip; v.esp_out = esp_out; v.halt = halt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, {31'h0, STALL_AG}, 32'h0);
      chk({tag, "_busy"},  {31'h0, BUSY}, 32'h0);
      chk({tag, "_flush"}, {31'h0, FLUSH}, 32'h0);
      chk({tag, "_req"},   {31'h0, MEM_WR_REQ}, 32'h0);
      chk({tag, "_addr"},  MEM_WR_ADDR, 32'h0);
      chk({tag, "_data"},  MEM_WR_DATA, 32'h0);
      chk({tag, "_ldeip"}, {31'h0, LD_EIP}, 32'h0);
      chk({tag, "_ldesp"}, {31'h0, LD_ESP}, 32'h0);
      chk({tag, "_neweip"}, NEW_EIP, 32'h0);
      chk({tag, "_espout"}, ESP_OUT, 32'h0);
      chk({tag, "_halt"},  {31'h0, HALT}, 32'h0);
   endtask

   task automatic clear_inputs();
      AG_V = 0; AG_EXC = 0; AG_SEG_ID = 0; AG_EIP = 0; AG_CS = 0;
      EFLAGS = 0; ESP = 0; OLDER_EMPTY = 0; MEM_WR_ACK = 0; PUSH_EXC = 0;
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      RST = 1;
      clear_inputs();
      @(negedge CLK);
      chk_all_zero(tag);
      RST = 0;
   endtask

   task automatic run_case(input vec_t v, input int id);
      int   drain_cnt = 0, nwr = 0, hold = 0, flushes = 0, post = 0;
      logic prev_req = 0, acked_last = 0, gap_exp;
      logic [31:0] prev_addr = 0, prev_data = 0;
      bit   done = 0, lde_seen = 0, halt_seen = 0;
      string tg = $sformatf("c%0d", id);

      @(negedge CLK);
      AG_V = 1; AG_EXC = 1; AG_SEG_ID = v.seg; AG_EIP = v.eip; AG_CS = v.cs;
      EFLAGS = v.efl; ESP = v.esp; OLDER_EMPTY = (v.drain == 0);
      @(negedge CLK);
      AG_V = 0; AG_EXC = 0;
      chk({tg, "_busy_after_capture"},  {31'h0, BUSY}, 32'h1);
      chk({tg, "_stall_after_capture"}, {31'h0, STALL_AG}, 32'h1);

      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         if (lde_seen) begin
            chk({tg, "_busy_after_redirect"}, {31'h0, BUSY}, 32'h0);
            chk({tg, "_ldeip_one_cycle"}, {31'h0, LD_EIP}, 32'h0);
            done = 1;
         end else begin
            if (FLUSH) begin
               flushes++;
               chk({tg, "_flush_after_drain"}, {31'h0, OLDER_EMPTY}, 32'h1);
               chk({tg, "_flush_ldeip_excl"}, {31'h0, LD_EIP}, 32'h0);
            end
            gap_exp    = acked_last;
            acked_last = 0;
            MEM_WR_ACK = 0;
            PUSH_EXC   = 0;
            if (gap_exp) begin
               chk({tg, "_req_gap"}, {31'h0, MEM_WR_REQ}, 32'h0);
            end else if (MEM_WR_REQ) begin
               if (prev_req) begin
                  chk({tg, "_addr_stable"}, MEM_WR_ADDR, prev_addr);
                  chk({tg, "_data_stable"}, MEM_WR_DATA, prev_data);
               end else begin
                  hold = 0;
               end
               if (hold == v.ack_dly) begin
                  MEM_WR_ACK = 1;
                  if (nwr == v.exc_push) PUSH_EXC = 1;
                  if (nwr < 4) begin
                     chk($sformatf("%s_wr%0d_addr", tg, nwr), MEM_WR_ADDR, v.addr[nwr]);
                     chk($sformatf("%s_wr%0d_data", tg, nwr), MEM_WR_DATA, v.data[nwr]);
                  end
                  nwr++;
                  acked_last = 1;
               end else begin
                  hold++;
               end
            end
            prev_req  = MEM_WR_REQ && !gap_exp;
            prev_addr = MEM_WR_ADDR;
            prev_data = MEM_WR_DATA;
            if (LD_EIP) begin
               lde_seen = 1;
               chk({tg, "_new_eip"}, NEW_EIP, v.new_eip);
               chk({tg, "_esp_out"}, ESP_OUT, v.esp_out);
               chk({tg, "_ld_esp"}, {31'h0, LD_ESP}, 32'h1);
               chk({tg, "_busy_at_redirect"}, {31'h0, BUSY}, 32'h1);
            end
            if (HALT) halt_seen = 1;
            if (halt_seen) begin
               chk({tg, "_halt_held"}, {31'h0, HALT}, 32'h1);
               chk({tg, "_stall_in_halt"}, {31'h0, STALL_AG}, 32'h1);
               chk({tg, "_no_req_in_halt"}, {31'h0, MEM_WR_REQ}, 32'h0);
               post++;
               if (post == 8) done = 1;
            end
            drain_cnt++;
            if (drain_cnt >= v.drain) OLDER_EMPTY = 1;
         end
         if (!done) @(negedge CLK);
      end

      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no completion expected redirect or halt", tg);
      end
      MEM_WR_ACK = 0;
      PUSH_EXC = 0;
      OLDER_EMPTY = 0;
      chk({tg, "_write_count"}, nwr, v.n_wr);
      chk({tg, "_flush_count"}, flushes, 32'd1);
      chk({tg, "_halt_seen"}, {31'h0, halt_seen}, {31'h0, v.halt});
      chk({tg, "_redirect_seen"}, {31'h0, lde_seen}, {31'h0, !v.halt});
      if (v.halt) do_reset({tg, "_post_halt_reset"});
   endtask

   initial begin
      int wait_cnt;

      // addr/data fields are written push3..push0 (push0 rightmost)
      vecs[0] = mk(3'd3, 32'h1000, 16'h0008, 32'h202, 32'h8000, 0, 0, -1, 4,
                   {32'h7FF0, 32'h7FF4, 32'h7FF8, 32'h7FFC},
                   {32'h0, 32'h1000, 32'h8, 32'h202}, 32'h68, 32'h7FF0, 1'b0);
      vecs[1] = mk(3'd2, 32'h1000, 16'h0008, 32'h202, 32'h8000, 0, 0, -1, 4,
                   {32'h7FF0, 32'h7FF4, 32'h7FF8, 32'h7FFC},
                   {32'h0, 32'h1000, 32'h8, 32'h202}, 32'h60, 32'h7FF0, 1'b0);
      vecs[2] = mk(3'd5, 32'h2345_6789, 16'h001B, 32'h46, 32'h0001_0000, 5, 3, -1, 4,
                   {32'hFFF0, 32'hFFF4, 32'hFFF8, 32'hFFFC},
                   {32'h0, 32'h2345_6789, 32'h1B, 32'h46}, 32'h68, 32'hFFF0, 1'b0);
      vecs[3] = mk(3'd3, 32'h1000, 16'h0008, 32'h202, 32'h8, 0, 0, -1, 4,
                   {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4},
                   {32'h0, 32'h1000, 32'h8, 32'h202}, 32'h68, 32'hFFFF_FFF8, 1'b0);
      vecs[4] = mk(3'd2, 32'h1000, 16'h0008, 32'h202, 32'h8000, 1, 1, 1, 2,
                   {32'h7FF0, 32'h7FF4, 32'h7FF8, 32'h7FFC},
                   {32'h0, 32'h1000, 32'h8, 32'h202}, 32'h0, 32'h0, 1'b1);

      RST = 1;
      clear_inputs();
      repeat (2) @(negedge CLK);
      chk_all_zero("reset");
      RST = 0;

      for (int i = 0; i < 5; i++) run_case(vecs[i], i);

      // reset while the first push request is outstanding
      @(negedge CLK);
      AG_V = 1; AG_EXC = 1; AG_SEG_ID = 3'd3; AG_EIP = 32'h1000; AG_CS = 16'h8;
      EFLAGS = 32'h202; ESP = 32'h8000; OLDER_EMPTY = 1;
      @(negedge CLK);
      AG_V = 0; AG_EXC = 0;
      wait_cnt = 0;
      while (!MEM_WR_REQ && wait_cnt < 20) begin
         @(negedge CLK);
         wait_cnt++;
      end
      chk("midpush_req_seen", {31'h0, MEM_WR_REQ}, 32'h1);
      RST = 1;
      @(negedge CLK);
      chk("midpush_req_drop", {31'h0, MEM_WR_REQ}, 32'h0);
      chk("midpush_busy", {31'h0, BUSY}, 32'h0);
      chk("midpush_stall", {31'h0, STALL_AG}, 32'h0);
      RST = 0;
      OLDER_EMPTY = 0;

      // AG_EXC without AG_V must not capture
      AG_V = 0; AG_EXC = 1; AG_SEG_ID = 3'd2;
      repeat (3) @(negedge CLK);
      chk("spurious_exc_busy", {31'h0, BUSY}, 32'h0);
      chk("spurious_exc_flush", {31'h0, FLUSH}, 32'h0);
      AG_EXC = 0;

      run_case(vecs[0], 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
